gat_bram_packer: RTL and testbench
==================================

Name: gat_bram_packer

Overview:
- Multi-channel load bridge between the 32-bit BRAM-controller write bus from the host and the accelerator's wide internal BRAM write ports.
- Decodes the byte address into channel, word address and beat index, then packs successive 32-bit beats into DATA_W-wide words.
- Counts the words loaded per channel and raises load_done per channel against a programmed depth.
- Replaces per-buffer slicing/load-done handshakes by host software; sits between the register-bank/BRAM-controller side and gat_top's buffer write ports.

Parameters:
- TOP_WIDTH, 32: host bus data width.
- NUM_CH, 3: number of target buffers (H data, node info, weight).
- DATA_W, 64: packed word width; all channels share it, and narrower buffers use the LSBs.
- ADDR_W, 18: word-address width per channel.
- BEATS, ceil(DATA_W/TOP_WIDTH): beats per word (derived, ≥1).
- BEAT_W, max(1,clog2(BEATS)): beat-index field width (derived).
- CH_W, max(1,clog2(NUM_CH)): channel field width (derived).
- S_ADDR_W, CH_W+ADDR_W+BEAT_W+2: host byte-address width (derived).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- s_din  in  TOP_WIDTH  host write data
- s_ena  in  1  host enable
- s_wea  in  1  host write enable
- s_addr  in  S_ADDR_W  byte address; fields from LSB: [1:0] ignored, beat, word address, channel
- cfg_start  in  1  pulse: clear counters, done flags and errors
- cfg_depth  in  NUM_CH*(ADDR_W+1)  expected word count per channel; 0 = channel unused
- m_wr_en  out  NUM_CH  per-channel write strobe
- m_wr_addr  out  NUM_CH*ADDR_W  per-channel word address
- m_wr_data  out  NUM_CH*DATA_W  per-channel packed word
- load_done  out  NUM_CH  sticky, per channel
- all_done  out  1  AND of load_done over channels with cfg_depth≠0; 0 if all depths are 0
- err_order  out  NUM_CH  sticky beat-sequence error
- err_ovf  out  NUM_CH  sticky write-after-done
- err_decode  out  1  sticky, channel field ≥ NUM_CH

Behaviour:
- Reset (rst=1 at a clk edge): all outputs 0; staging registers, beat counters and word counters cleared; every channel in IDLE.
- A beat is accepted only when s_ena&&s_wea. s_ena without s_wea is ignored (no read path).
- Per-channel FSM:
  - IDLE→FILL on beat 0.
  - FILL→FILL while beats arrive as expected_beat with the same word address.
  - On beat BEATS-1: FILL→IDLE, or →DONE if the count reaches depth.
  - DONE holds until cfg_start or rst.
  - BEATS=1: each accepted beat completes a word directly.
- Beat k is stored in staging bits [k*TOP_WIDTH +: TOP_WIDTH]. For the last beat, bits beyond DATA_W are dropped.
- Latency: m_wr_en pulses exactly 1 cycle after the last beat is accepted, with the address of that word and the fully assembled data. m_wr_data/m_wr_addr hold their value when m_wr_en=0.
- Word counter (ADDR_W+1 bits) increments on each m_wr_en. load_done rises in the same cycle as the m_wr_en that makes count==cfg_depth[ch] (cfg_depth≠0).
- Order error, set err_order[ch]: a beat index ≠ expected_beat, or a word-address change mid-word.
  - Partial word is discarded; no write.
  - If the offending beat is beat 0, it starts a new word; otherwise the channel returns to IDLE.
- In DONE: further beats are not written, err_ovf[ch] is set, and the counter is frozen.
- Channel field ≥ NUM_CH: beat dropped, err_decode set.
- cfg_start with a beat in the same cycle: cfg_start wins, beat dropped. A write strobe already registered for this cycle still issues.
- rst mid-word: partial data lost; no write issued.
- Only one host beat per cycle, so at most one m_wr_en bit is high per cycle.

Decomposition:
- Package gat_bram_pkg:
  - TOP_WIDTH constant.
  - Address-field offset localparams and a field-extract function.
  - Channel enum (CH_H_DATA=0, CH_NODE_INFO=1, CH_WGT=2).
  - Per-channel state enum IDLE/FILL/DONE.
- Sub-module gat_beat_packer: one channel's FSM, staging, counter and flags, instantiated NUM_CH times. The top level does only decode, all_done and error OR-ing.

Test Plan:
- Defaults (BEATS=2), cfg_depth={0,0,2}. Writes 0x11111111 @0x00 and 0x22222222 @0x04 on ch0 → m_wr_en[0] one cycle later, addr 0, data 0x2222222211111111; load_done[0]=0.
- Continue ch0 word 1 (byte addr 0x08/0x0C) → second write; load_done[0]=1 the same cycle; all_done=1 (ch1 unused, depth 0).
- ch1: beat 1 first (byte 0x04 plus ch1 offset) → err_order[1]=1, no write; then a correct pair → normal write at addr 0.
- After ch0 is done, write beat 0 again → no m_wr_en, err_ovf[0]=1, counter stays 2.
- Channel field=3 → err_decode=1, no output activity. cfg_start in the same cycle as a beat → beat dropped, all flags cleared next cycle.
- rst asserted between beat 0 and beat 1 → outputs 0 next cycle; a subsequent lone beat 1 → err_order set, no write.

Source files
------------

// File: rtl/gat_bram_packer_pkg.sv
// Shared constants, enums and address-field helpers for the GAT BRAM load bridge.
package gat_bram_pkg;
  localparam int unsigned TOP_WIDTH = 32;
  localparam int unsigned BEAT_LSB  = 2;

  typedef enum logic [1:0] {
    CH_H_DATA    = 2'd0,
    CH_NODE_INFO = 2'd1,
    CH_WGT       = 2'd2
  } gat_ch_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } pk_state_e;

  // Returns the `width`-bit field of a host byte address starting at bit `lsb`.
  function automatic logic [31:0] addr_field(input logic [63:0] addr,
                                             input int unsigned lsb,
                                             input int unsigned width);
    logic [63:0] mask_s;
    mask_s = (64'd1 << width) - 64'd1;
    return 32'((addr >> lsb) & mask_s);
  endfunction
endpackage

// File: rtl/gat_bram_packer_beat.sv
// One channel of the BRAM load bridge: beat staging, word assembly, word count and sticky flags.
module gat_beat_packer
  import gat_bram_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned BEATS  = 2,
  parameter int unsigned BEAT_W = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic                 beat_valid,
  input  logic [BEAT_W-1:0]    beat_idx,
  input  logic [ADDR_W-1:0]    word_addr,
  input  logic [TOP_WIDTH-1:0] din,
  input  logic [ADDR_W:0]      depth,
  output logic                 wr_en,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [DATA_W-1:0]    wr_data,
  output logic                 load_done,
  output logic                 err_order,
  output logic                 err_ovf
);
  localparam int unsigned   STG_W    = BEATS * TOP_WIDTH;
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);

  pk_state_e         state_r;
  logic [BEAT_W-1:0] exp_beat_r;
  logic [ADDR_W-1:0] cur_addr_r;
  logic [STG_W-1:0]  stage_r;
  logic [ADDR_W:0]   cnt_r;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic              load_done_r;
  logic              err_order_r;
  logic              err_ovf_r;

  logic [STG_W-1:0]  full_s;
  logic              in_order_s;
  logic              last_s;
  logic              take_s;
  logic              order_err_s;
  logic              complete_s;
  logic [ADDR_W:0]   cnt_inc_s;

  // Merge the incoming beat into the staged word and classify it against the expected sequence.
  always_comb begin
    full_s = stage_r;
    for (int k = 0; k < int'(BEATS); k++) begin
      if (beat_idx == BEAT_W'(k)) begin
        full_s[k*TOP_WIDTH +: TOP_WIDTH] = din;
      end else begin
        full_s[k*TOP_WIDTH +: TOP_WIDTH] = stage_r[k*TOP_WIDTH +: TOP_WIDTH];
      end
    end
    in_order_s  = (beat_idx == exp_beat_r) && (word_addr == cur_addr_r);
    last_s      = (beat_idx == BEAT_W'(BEATS - 1));
    take_s      = 1'b0;
    order_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        take_s      = beat_valid && (beat_idx == BEAT_W'(0));
        order_err_s = beat_valid && (beat_idx != BEAT_W'(0));
      end
      // A stray beat 0 mid-word is both an error and the start of a fresh word.
      FILL: begin
        take_s      = beat_valid && (in_order_s || (beat_idx == BEAT_W'(0)));
        order_err_s = beat_valid && !in_order_s;
      end
      default: begin
        take_s      = 1'b0;
        order_err_s = 1'b0;
      end
    endcase
    complete_s = take_s && last_s;
    cnt_inc_s  = cnt_r + CNT_ONE;
  end

  // Channel sequencing: reset, cfg_start clear, then beat acceptance and word completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      exp_beat_r  <= '0;
      cur_addr_r  <= '0;
      stage_r     <= '0;
      cnt_r       <= '0;
      wr_en_r     <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= '0;
      load_done_r <= 1'b0;
      err_order_r <= 1'b0;
      err_ovf_r   <= 1'b0;
    end else begin
      wr_en_r <= 1'b0;
      if (cfg_start) begin
        state_r     <= IDLE;
        exp_beat_r  <= '0;
        cnt_r       <= '0;
        load_done_r <= 1'b0;
        err_order_r <= 1'b0;
        err_ovf_r   <= 1'b0;
      end else begin
        if (order_err_s) err_order_r <= 1'b1;
        if (beat_valid && (state_r == DONE)) err_ovf_r <= 1'b1;
        if (complete_s) begin
          wr_en_r    <= 1'b1;
          wr_addr_r  <= word_addr;
          wr_data_r  <= full_s[DATA_W-1:0];
          cnt_r      <= cnt_inc_s;
          exp_beat_r <= '0;
          if ((depth != '0) && (cnt_inc_s == depth)) begin
            load_done_r <= 1'b1;
            state_r     <= DONE;
          end else begin
            state_r <= IDLE;
          end
        end else if (take_s) begin
          stage_r    <= full_s;
          cur_addr_r <= word_addr;
          exp_beat_r <= beat_idx + BEAT_ONE;
          state_r    <= FILL;
        end else if (order_err_s) begin
          state_r    <= IDLE;
          exp_beat_r <= '0;
        end
      end
    end
  end

  assign wr_en     = wr_en_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign load_done = load_done_r;
  assign err_order = err_order_r;
  assign err_ovf   = err_ovf_r;
endmodule

// File: rtl/gat_bram_packer.sv
// Multi-channel load bridge: decodes host byte addresses and packs 32-bit beats into wide BRAM words.
module gat_bram_packer
  import gat_bram_pkg::*;
#(
  parameter  int unsigned NUM_CH   = 3,
  parameter  int unsigned DATA_W   = 64,
  parameter  int unsigned ADDR_W   = 18,
  localparam int unsigned BEATS    = (DATA_W + TOP_WIDTH - 1) / TOP_WIDTH,
  localparam int unsigned BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1,
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned S_ADDR_W = CH_W + ADDR_W + BEAT_W + 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [TOP_WIDTH-1:0]       s_din,
  input  logic                       s_ena,
  input  logic                       s_wea,
  input  logic [S_ADDR_W-1:0]        s_addr,
  input  logic                       cfg_start,
  input  logic [NUM_CH*(ADDR_W+1)-1:0] cfg_depth,
  output logic [NUM_CH-1:0]          m_wr_en,
  output logic [NUM_CH*ADDR_W-1:0]   m_wr_addr,
  output logic [NUM_CH*DATA_W-1:0]   m_wr_data,
  output logic [NUM_CH-1:0]          load_done,
  output logic                       all_done,
  output logic [NUM_CH-1:0]          err_order,
  output logic [NUM_CH-1:0]          err_ovf,
  output logic                       err_decode
);
  localparam int unsigned WA_LSB = BEAT_LSB + BEAT_W;
  localparam int unsigned CH_LSB = WA_LSB + ADDR_W;

  logic [CH_W-1:0]   ch_s;
  logic [ADDR_W-1:0] word_s;
  logic [BEAT_W-1:0] beat_s;
  logic              beat_acc_s;
  logic              dec_ok_s;
  logic [NUM_CH-1:0] ch_valid_s;
  logic [NUM_CH-1:0] used_s;
  logic              err_decode_r;

  // Split the byte address into fields and steer the accepted beat to one channel.
  always_comb begin
    ch_s       = CH_W'(addr_field(64'(s_addr), CH_LSB, CH_W));
    word_s     = ADDR_W'(addr_field(64'(s_addr), WA_LSB, ADDR_W));
    beat_s     = BEAT_W'(addr_field(64'(s_addr), BEAT_LSB, BEAT_W));
    beat_acc_s = s_ena && s_wea;
    dec_ok_s   = ({1'b0, ch_s} < (CH_W + 1)'(NUM_CH));
    for (int c = 0; c < int'(NUM_CH); c++) begin
      ch_valid_s[c] = beat_acc_s && dec_ok_s && (ch_s == CH_W'(c));
      used_s[c]     = (cfg_depth[c*(ADDR_W+1) +: ADDR_W+1] != '0);
    end
  end

  // Sticky decode error for beats aimed past the last channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_decode_r <= 1'b0;
    end else if (cfg_start) begin
      err_decode_r <= 1'b0;
    end else if (beat_acc_s && !dec_ok_s) begin
      err_decode_r <= 1'b1;
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    gat_beat_packer #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .BEATS  (BEATS),
      .BEAT_W (BEAT_W)
    ) u_packer (
      .clk        (clk),
      .rst        (rst),
      .cfg_start  (cfg_start),
      .beat_valid (ch_valid_s[c]),
      .beat_idx   (beat_s),
      .word_addr  (word_s),
      .din        (s_din),
      .depth      (cfg_depth[c*(ADDR_W+1) +: ADDR_W+1]),
      .wr_en      (m_wr_en[c]),
      .wr_addr    (m_wr_addr[c*ADDR_W +: ADDR_W]),
      .wr_data    (m_wr_data[c*DATA_W +: DATA_W]),
      .load_done  (load_done[c]),
      .err_order  (err_order[c]),
      .err_ovf    (err_ovf[c])
    );
  end

  // Unused channels (depth 0) do not hold up all_done; with no channel in use it stays low.
  assign all_done   = (|used_s) && (&(load_done | ~used_s));
  assign err_decode = err_decode_r;
endmodule

// File: tb/tb_gat_bram_packer.sv
// Directed plus randomized bench for gat_bram_packer against a beat-list reference model.
module tb_gat_bram_packer;
  import gat_bram_pkg::*;

  localparam int NCH = 3;
  localparam int DW  = 64;
  localparam int AW  = 18;
  localparam int SAW = 23;

  logic             clk;
  logic             rst;
  logic [31:0]      s_din;
  logic             s_ena;
  logic             s_wea;
  logic [SAW-1:0]   s_addr;
  logic             cfg_start;
  logic [NCH*(AW+1)-1:0] cfg_depth;
  logic [NCH-1:0]   m_wr_en;
  logic [NCH*AW-1:0] m_wr_addr;
  logic [NCH*DW-1:0] m_wr_data;
  logic [NCH-1:0]   load_done;
  logic             all_done;
  logic [NCH-1:0]   err_order;
  logic [NCH-1:0]   err_ovf;
  logic             err_decode;

  int checks = 0;
  int errors = 0;

  // Reference model: collected beats per channel plus observable results.
  logic [31:0] mb [NCH][2];
  int          have [NCH];
  logic [17:0] pwa [NCH];
  int          cnt [NCH];
  bit          done_m [NCH];
  bit          eo_m [NCH];
  bit          ev_m [NCH];
  bit          wen_m [NCH];
  logic [17:0] waddr_m [NCH];
  logic [63:0] wdata_m [NCH];
  bit          dec_m;

  gat_bram_packer #(.NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW)) u_dut (
    .clk (clk), .rst (rst), .s_din (s_din), .s_ena (s_ena), .s_wea (s_wea),
    .s_addr (s_addr), .cfg_start (cfg_start), .cfg_depth (cfg_depth),
    .m_wr_en (m_wr_en), .m_wr_addr (m_wr_addr), .m_wr_data (m_wr_data),
    .load_done (load_done), .all_done (all_done), .err_order (err_order),
    .err_ovf (err_ovf), .err_decode (err_decode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      $error("check %s", tag);
    end
  endtask

  function automatic int depth_of(int c);
    return int'((cfg_depth >> (c * (AW + 1))) & 57'h7FFFF);
  endfunction

  function automatic bit exp_all_done();
    bit any_used = 1'b0;
    bit all_ok   = 1'b1;
    for (int c = 0; c < NCH; c++) begin
      if (depth_of(c) != 0) begin
        any_used = 1'b1;
        if (!done_m[c]) all_ok = 1'b0;
      end
    end
    return any_used && all_ok;
  endfunction

  task automatic model_step();
    int ch;
    int b;
    logic [17:0] wa;
    for (int c = 0; c < NCH; c++) wen_m[c] = 1'b0;
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        have[c] = 0; cnt[c] = 0; done_m[c] = 0; eo_m[c] = 0; ev_m[c] = 0;
        waddr_m[c] = '0; wdata_m[c] = '0;
      end
      dec_m = 1'b0;
    end else if (cfg_start) begin
      for (int c = 0; c < NCH; c++) begin
        have[c] = 0; cnt[c] = 0; done_m[c] = 0; eo_m[c] = 0; ev_m[c] = 0;
      end
      dec_m = 1'b0;
    end else if (s_ena && s_wea) begin
      ch = int'(s_addr[22:21]);
      wa = s_addr[20:3];
      b  = int'(s_addr[2]);
      if (ch >= NCH) begin
        dec_m = 1'b1;
      end else if (done_m[ch]) begin
        ev_m[ch] = 1'b1;
      end else if (b == have[ch] && (have[ch] == 0 || wa == pwa[ch])) begin
        mb[ch][b] = s_din;
        if (have[ch] == 0) pwa[ch] = wa;
        have[ch]++;
        if (have[ch] == 2) begin
          wen_m[ch]   = 1'b1;
          waddr_m[ch] = pwa[ch];
          wdata_m[ch] = {mb[ch][1], mb[ch][0]};
          have[ch]    = 0;
          cnt[ch]++;
          if (depth_of(ch) != 0 && cnt[ch] == depth_of(ch)) done_m[ch] = 1'b1;
        end
      end else begin
        eo_m[ch] = 1'b1;
        if (b == 0) begin
          mb[ch][0] = s_din; pwa[ch] = wa; have[ch] = 1;
        end else begin
          have[ch] = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int c = 0; c < NCH; c++) begin
      check($sformatf("wr_en[%0d]", c), 64'(m_wr_en[c]), 64'(wen_m[c]));
      check($sformatf("wr_addr[%0d]", c), 64'(m_wr_addr[c*AW +: AW]), 64'(waddr_m[c]));
      check($sformatf("wr_data[%0d]", c), m_wr_data[c*DW +: DW], wdata_m[c]);
      check($sformatf("load_done[%0d]", c), 64'(load_done[c]), 64'(done_m[c]));
      check($sformatf("err_order[%0d]", c), 64'(err_order[c]), 64'(eo_m[c]));
      check($sformatf("err_ovf[%0d]", c), 64'(err_ovf[c]), 64'(ev_m[c]));
    end
    check("err_decode", 64'(err_decode), 64'(dec_m));
    check("all_done", 64'(all_done), 64'(exp_all_done()));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic drive_beat(input int ch, input int wa, input int b, input logic [31:0] d);
    s_addr = SAW'((ch << 21) | (wa << 3) | (b << 2));
    s_din  = d;
    s_ena  = 1'b1;
    s_wea  = 1'b1;
    step();
    s_ena  = 1'b0;
    s_wea  = 1'b0;
  endtask

  initial begin
    int r;
    int ch;
    int wa;
    int b;
    int seq [NCH];
    rst = 1'b1; cfg_start = 1'b0; s_ena = 1'b0; s_wea = 1'b0;
    s_addr = '0; s_din = '0; cfg_depth = '0;
    for (int c = 0; c < NCH; c++) seq[c] = 0;
    step();
    step();
    check("reset_wr_en", 64'(m_wr_en), 64'd0);
    rst = 1'b0;

    cfg_depth = {19'd0, 19'd0, 19'd2};
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;

    drive_beat(int'(CH_H_DATA), 0, 0, 32'h11111111);
    drive_beat(int'(CH_H_DATA), 0, 1, 32'h22222222);
    check("tp_word0_en", 64'(m_wr_en), 64'd1);
    check("tp_word0_data", m_wr_data[63:0], 64'h2222222211111111);
    check("tp_word0_done", 64'(load_done[0]), 64'd0);
    step();
    check("tp_en_pulse", 64'(m_wr_en), 64'd0);

    drive_beat(int'(CH_H_DATA), 1, 0, 32'h33333333);
    drive_beat(int'(CH_H_DATA), 1, 1, 32'h44444444);
    check("tp_word1_addr", 64'(m_wr_addr[AW-1:0]), 64'd1);
    check("tp_word1_done", 64'(load_done[0]), 64'd1);
    check("tp_all_done", 64'(all_done), 64'd1);

    drive_beat(int'(CH_NODE_INFO), 0, 1, 32'hDEADBEEF);
    check("tp_ch1_order", 64'(err_order[1]), 64'd1);
    check("tp_ch1_nowr", 64'(m_wr_en), 64'd0);
    drive_beat(int'(CH_NODE_INFO), 0, 0, 32'hA5A5A5A5);
    drive_beat(int'(CH_NODE_INFO), 0, 1, 32'h5A5A5A5A);
    check("tp_ch1_wr", m_wr_data[127:64], 64'h5A5A5A5AA5A5A5A5);

    drive_beat(int'(CH_H_DATA), 2, 0, 32'h77777777);
    check("tp_ovf", 64'(err_ovf[0]), 64'd1);
    check("tp_ovf_nowr", 64'(m_wr_en), 64'd0);

    s_ena = 1'b1; s_wea = 1'b0; s_addr = SAW'(32'h0020_0000); s_din = 32'h1;
    step();
    s_ena = 1'b0;

    drive_beat(3, 0, 0, 32'hCAFEF00D);
    check("tp_decode", 64'(err_decode), 64'd1);
    check("tp_decode_nowr", 64'(m_wr_en), 64'd0);

    cfg_start = 1'b1;
    drive_beat(int'(CH_NODE_INFO), 1, 0, 32'h12345678);
    cfg_start = 1'b0;
    check("tp_start_flags", 64'({err_order, err_ovf, load_done, err_decode}), 64'd0);
    check("tp_start_nowr", 64'(m_wr_en), 64'd0);

    drive_beat(int'(CH_WGT), 0, 0, 32'h99999999);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("tp_rst_data", m_wr_data[191:128], 64'd0);
    check("tp_rst_en", 64'(m_wr_en), 64'd0);
    drive_beat(int'(CH_WGT), 0, 1, 32'h88888888);
    check("tp_rst_order", 64'(err_order[2]), 64'd1);
    check("tp_rst_nowr", 64'(m_wr_en), 64'd0);

    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      rst       = (r < 2);
      cfg_start = (r >= 2 && r < 5);
      if (cfg_start) begin
        cfg_depth = {19'($urandom_range(0, 4)), 19'($urandom_range(0, 4)),
                     19'($urandom_range(0, 4))};
      end
      s_ena = ($urandom_range(0, 9) < 7);
      s_wea = ($urandom_range(0, 9) < 9);
      ch = ($urandom_range(0, 19) == 0) ? 3 : int'($urandom_range(0, 2));
      if (ch < NCH && $urandom_range(0, 9) < 8) begin
        wa = seq[ch] / 2;
        b  = seq[ch] % 2;
        seq[ch]++;
      end else begin
        wa = int'($urandom_range(0, 3));
        b  = int'($urandom_range(0, 1));
      end
      s_addr = SAW'((ch << 21) | (wa << 3) | (b << 2));
      s_din  = $urandom;
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
